// File: rtl/program_counter_stack_pkg.sv
// Shared defaults and helpers for the fetch-side program counter / return stack.
//   PCS_ADDR_WIDTH  : default PC / target / stack entry width
//   PCS_STACK_DEPTH : default number of return-address entries (>= 2)
//   PCS_RESET_ADDR  : default PC value after reset
//   PCS_DEPTH_W     : width of the depth counter, clog2(STACK_DEPTH+1)
package program_counter_stack_pkg;

   localparam int unsigned PCS_ADDR_WIDTH  = 16;
   localparam int unsigned PCS_STACK_DEPTH = 8;
   localparam int unsigned PCS_RESET_ADDR  = 0;

   // Counter width able to hold 0..depth inclusive.
   function automatic int unsigned depth_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   localparam int unsigned PCS_DEPTH_W = depth_width(PCS_STACK_DEPTH);

endpackage

// File: rtl/program_counter_stack_ras.sv
// Register-array LIFO holding return addresses.
//   clk, rst     : clock, synchronous active-high reset (clears depth only)
//   push, pop    : push push_data / drop top entry; push-when-full and
//                  pop-when-empty are no-ops
//   top_data     : most recently pushed entry (zero when empty)
//   depth        : number of valid entries
//   full, empty  : depth == DEPTH / depth == 0
module return_address_stack
   import program_counter_stack_pkg::*;
#(
   parameter int unsigned WIDTH = PCS_ADDR_WIDTH,
   parameter int unsigned DEPTH = PCS_STACK_DEPTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic                          pop,
   input  logic [WIDTH-1:0]              push_data,
   output logic [WIDTH-1:0]              top_data,
   output logic [depth_width(DEPTH)-1:0] depth,
   output logic                          full,
   output logic                          empty
);

   localparam int unsigned DW    = depth_width(DEPTH);
   localparam int unsigned IDX_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [DW-1:0]    cnt;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] top_idx;

   assign full    = (cnt == DW'(DEPTH));
   assign empty   = (cnt == '0);
   assign depth   = cnt;
   // wr_idx is only used while not full, top_idx only while not empty.
   assign wr_idx  = IDX_W'(cnt);
   assign top_idx = IDX_W'(cnt - DW'(1));
   assign top_data = empty ? '0 : mem[top_idx];

   // Occupancy counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (push && !full) begin
         cnt <= cnt + DW'(1);
      end else if (pop && !empty) begin
         cnt <= cnt - DW'(1);
      end
   end

   // Entry storage; contents are meaningless after reset, so no reset here.
   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[wr_idx] <= push_data;
      end
   end

endmodule

// File: rtl/program_counter_stack.sv
// Instruction-fetch sequencer: program counter plus hardware return stack.
//   Clock, Reset  : clock, synchronous active-high reset
//   iEnable       : 1 = advance, 0 = stall (all state holds)
//   iJump/iCall/iRet, iTarget : control requests, priority ret > call > jump
//   oAddress      : registered PC to the instruction ROM
//   oStackDepth/oStackFull/oStackEmpty : return-stack occupancy
//   oOverflow/oUnderflow : sticky call-when-full / ret-when-empty flags
module program_counter_stack
   import program_counter_stack_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = PCS_ADDR_WIDTH,
   parameter int unsigned STACK_DEPTH = PCS_STACK_DEPTH,
   parameter int unsigned RESET_ADDR  = PCS_RESET_ADDR
) (
   input  logic                                Clock,
   input  logic                                Reset,
   input  logic                                iEnable,
   input  logic                                iJump,
   input  logic                                iCall,
   input  logic                                iRet,
   input  logic [ADDR_WIDTH-1:0]               iTarget,
   output logic [ADDR_WIDTH-1:0]               oAddress,
   output logic [depth_width(STACK_DEPTH)-1:0] oStackDepth,
   output logic                                oStackFull,
   output logic                                oStackEmpty,
   output logic                                oOverflow,
   output logic                                oUnderflow
);

   logic [ADDR_WIDTH-1:0] pc;
   logic [ADDR_WIDTH-1:0] pc_next;
   logic [ADDR_WIDTH-1:0] pc_inc;
   logic [ADDR_WIDTH-1:0] top_data;
   logic                  push;
   logic                  pop;
   logic                  ovf;
   logic                  unf;
   logic                  ovf_set;
   logic                  unf_set;
   logic                  full;
   logic                  empty;

   // Return address is always relative to the current PC; wraps naturally.
   assign pc_inc = pc + ADDR_WIDTH'(1);

   // Request arbitration and next-PC selection.
   always_comb begin
      pc_next = pc;
      push    = 1'b0;
      pop     = 1'b0;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      if (iEnable) begin
         if (iRet) begin
            if (!empty) begin
               pop     = 1'b1;
               pc_next = top_data;
            end else begin
               unf_set = 1'b1;
               pc_next = pc_inc;
            end
         end else if (iCall) begin
            pc_next = iTarget;
            if (!full) begin
               push = 1'b1;
            end else begin
               ovf_set = 1'b1;
            end
         end else if (iJump) begin
            pc_next = iTarget;
         end else begin
            pc_next = pc_inc;
         end
      end
   end

   // PC and sticky error flags.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         pc  <= ADDR_WIDTH'(RESET_ADDR);
         ovf <= 1'b0;
         unf <= 1'b0;
      end else begin
         pc <= pc_next;
         if (ovf_set) ovf <= 1'b1;
         if (unf_set) unf <= 1'b1;
      end
   end

   return_address_stack #(
      .WIDTH (ADDR_WIDTH),
      .DEPTH (STACK_DEPTH)
   ) u_ras (
      .clk       (Clock),
      .rst       (Reset),
      .push      (push),
      .pop       (pop),
      .push_data (pc_inc),
      .top_data  (top_data),
      .depth     (oStackDepth),
      .full      (full),
      .empty     (empty)
   );

   assign oAddress    = pc;
   assign oStackFull  = full;
   assign oStackEmpty = empty;
   assign oOverflow   = ovf;
   assign oUnderflow  = unf;

endmodule

// File: tb/tb_program_counter_stack.sv
module tb_program_counter_stack;

   logic        clk;
   logic        rst;
   logic        en;
   logic        jmp;
   logic        call;
   logic        ret;
   logic [15:0] tgt;
   logic [15:0] addr;
   logic [3:0]  depth;
   logic        full;
   logic        empty;
   logic        ovf;
   logic        unf;

   int tests  = 0;
   int failed = 0;

   typedef struct {
      logic        rst;
      logic        en;
      logic        jmp;
      logic        call;
      logic        ret;
      logic [15:0] tgt;
      logic [15:0] e_addr;
      logic [3:0]  e_depth;
      logic        e_ovf;
      logic        e_unf;
   } vec_t;

   vec_t vecs[$];

   program_counter_stack dut (
      .Clock       (clk),
      .Reset       (rst),
      .iEnable     (en),
      .iJump       (jmp),
      .iCall       (call),
      .iRet        (ret),
      .iTarget     (tgt),
      .oAddress    (addr),
      .oStackDepth (depth),
      .oStackFull  (full),
      .oStackEmpty (empty),
      .oOverflow   (ovf),
      .oUnderflow  (unf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic e, input logic j,
                               input logic c, input logic t, input logic [15:0] tg,
                               input logic [15:0] ea, input logic [3:0] ed,
                               input logic eo, input logic eu);
      vec_t v;
      v.rst = r; v.en = e; v.jmp = j; v.call = c; v.ret = t; v.tgt = tg;
      v.e_addr = ea; v.e_depth = ed; v.e_ovf = eo; v.e_unf = eu;
      return v;
   endfunction

   // Drive one cycle of inputs, clock it, then check all outputs.
   task automatic apply(input string name, input vec_t v);
      logic ef;
      logic ee;
      rst = v.rst; en = v.en; jmp = v.jmp; call = v.call; ret = v.ret; tgt = v.tgt;
      @(posedge clk);
      #1;
      ef = (v.e_depth == 4'd8);
      ee = (v.e_depth == 4'd0);
      tests++;
      if (addr !== v.e_addr || depth !== v.e_depth || full !== ef || empty !== ee ||
          ovf !== v.e_ovf || unf !== v.e_unf) begin
         failed++;
         $display("FAIL %s: got addr=%h depth=%0d full=%b empty=%b ovf=%b unf=%b, want addr=%h depth=%0d full=%b empty=%b ovf=%b unf=%b",
                  name, addr, depth, full, empty, ovf, unf,
                  v.e_addr, v.e_depth, ef, ee, v.e_ovf, v.e_unf);
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; jmp = 1'b0; call = 1'b0; ret = 1'b0; tgt = '0;

      // 1: reset then sequential fetch
      vecs.push_back(mk(1,0,0,0,0, 16'h0000, 16'd0, 0, 0, 0));
      for (int i = 1; i <= 5; i++)
         vecs.push_back(mk(0,1,0,0,0, 16'h0000, 16'(i), 0, 0, 0));
      // 2: single call / return
      vecs.push_back(mk(1,1,0,0,0, 16'h0000, 16'd0, 0, 0, 0));
      for (int i = 1; i <= 4; i++)
         vecs.push_back(mk(0,1,0,0,0, 16'h0000, 16'(i), 0, 0, 0));
      vecs.push_back(mk(0,1,0,1,0, 16'd14, 16'd14, 1, 0, 0));
      for (int i = 15; i <= 19; i++)
         vecs.push_back(mk(0,1,0,0,0, 16'h0000, 16'(i), 1, 0, 0));
      vecs.push_back(mk(0,1,0,0,1, 16'h0000, 16'd5, 0, 0, 0));
      // 3: nested calls
      vecs.push_back(mk(0,1,0,0,0, 16'h0000, 16'd6,  0, 0, 0));
      vecs.push_back(mk(0,1,0,1,0, 16'd9,    16'd9,  1, 0, 0));
      vecs.push_back(mk(0,1,0,0,0, 16'h0000, 16'd10, 1, 0, 0));
      vecs.push_back(mk(0,1,0,1,0, 16'd30,   16'd30, 2, 0, 0));
      vecs.push_back(mk(0,1,0,0,0, 16'h0000, 16'd31, 2, 0, 0));
      vecs.push_back(mk(0,1,0,0,1, 16'h0000, 16'd11, 1, 0, 0));
      vecs.push_back(mk(0,1,0,0,0, 16'h0000, 16'd12, 1, 0, 0));
      vecs.push_back(mk(0,1,0,0,1, 16'h0000, 16'd7,  0, 0, 0));
      // 5: priority (top = 0x0042) and stall
      vecs.push_back(mk(1,1,0,0,0, 16'h0000, 16'h0000, 0, 0, 0));
      vecs.push_back(mk(0,1,1,0,0, 16'h0041, 16'h0041, 0, 0, 0));
      vecs.push_back(mk(0,1,0,1,0, 16'h0080, 16'h0080, 1, 0, 0));
      vecs.push_back(mk(0,1,1,1,1, 16'h0010, 16'h0042, 0, 0, 0));
      for (int i = 0; i < 3; i++)
         vecs.push_back(mk(0,0,1,0,0, 16'h00FF, 16'h0042, 0, 0, 0));
      // call + jump: call wins, return address from PC not target
      vecs.push_back(mk(0,1,1,1,0, 16'h0300, 16'h0300, 1, 0, 0));
      vecs.push_back(mk(0,1,0,0,1, 16'h0000, 16'h0043, 0, 0, 0));
      // 6: wrap
      vecs.push_back(mk(0,1,1,0,0, 16'hFFFF, 16'hFFFF, 0, 0, 0));
      vecs.push_back(mk(0,1,0,0,0, 16'h0000, 16'h0000, 0, 0, 0));

      foreach (vecs[k]) apply($sformatf("vec%0d", k), vecs[k]);

      // 4: overflow / underflow chain starting at PC 7
      apply("ovf_rst", mk(1,1,0,0,0, 16'h0000, 16'd0, 0, 0, 0));
      apply("ovf_jmp7", mk(0,1,1,0,0, 16'd7, 16'd7, 0, 0, 0));
      for (int i = 1; i <= 9; i++)
         apply($sformatf("call%0d", i),
               mk(0,1,0,1,0, 16'd100, 16'd100, (i > 8) ? 4'd8 : 4'(i), (i == 9), 0));
      for (int i = 1; i <= 8; i++)
         apply($sformatf("ret%0d", i),
               mk(0,1,0,0,1, 16'h0000, (i == 8) ? 16'd8 : 16'd101, 4'(8 - i), 1, 0));
      apply("ret9_unf", mk(0,1,0,0,1, 16'h0000, 16'd9, 0, 1, 1));
      // stall must not touch sticky flags or PC even with ret requested
      apply("stall_ret", mk(0,0,0,0,1, 16'h0000, 16'd9, 0, 1, 1));

      // 6b: reset mid-chain with depth 3 and overflow set
      apply("r_rst", mk(1,1,0,0,0, 16'h0000, 16'd0, 0, 0, 0));
      for (int i = 1; i <= 9; i++)
         apply($sformatf("r_call%0d", i),
               mk(0,1,0,1,0, 16'h0200, 16'h0200, (i > 8) ? 4'd8 : 4'(i), (i == 9), 0));
      for (int i = 1; i <= 5; i++)
         apply($sformatf("r_ret%0d", i),
               mk(0,1,0,0,1, 16'h0000, 16'h0201, 4'(8 - i), 1, 0));
      apply("r_reset", mk(1,1,0,1,0, 16'h0055, 16'd0, 0, 0, 0));
      apply("r_after", mk(0,1,0,0,0, 16'h0000, 16'd1, 0, 0, 0));

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
